// File: rtl/hsym_packer.sv
// Packs pairs of 4-bit decoded symbols into bytes (low nibble first) and queues them in a small FIFO.
// Optional statistics outputs bit_count/sym_count are built only when HSYM_PACKER_STATS_EN is defined.
module hsym_packer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [3:0] sym_data,
    input  logic [3:0] sym_len,
    output logic       sym_ready,
    input  logic       flush,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [3:0] fifo_level
`ifdef HSYM_PACKER_STATS_EN
    ,
    output logic [15:0] bit_count,
    output logic [15:0] sym_count
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DepthL = 4'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        StEmpty,
        StHalf,
        StPad
    } state_e;

    state_e state_q, state_d;
    logic [3:0] nibble_q, nibble_d;
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [7:0] mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0] level_q, level_d;

    logic accept, pop, push, full;
    logic [7:0] push_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrMax) ? '0 : p + 1'b1;
    endfunction

    assign full       = (level_q == DepthL);
    assign byte_valid = (level_q != 4'd0);
    assign byte_data  = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign accept     = sym_valid & sym_ready;
    assign pop        = byte_valid & byte_ready;

    // Ready looks only at the registered level; a same-cycle pop does not free a slot.
    always_comb begin
        sym_ready = 1'b0;
        unique case (state_q)
            StEmpty: sym_ready = 1'b1;
            StHalf:  sym_ready = ~full;
            default: sym_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        nibble_d  = nibble_q;
        push      = 1'b0;
        push_data = 8'h00;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    nibble_d = sym_data;
                    state_d  = StHalf;
                end
            end
            StHalf: begin
                if (accept) begin
                    push      = 1'b1;
                    push_data = {sym_data, nibble_q};
                    state_d   = StEmpty;
                end else if (flush) begin
                    if (full) begin
                        state_d = StPad;
                    end else begin
                        push      = 1'b1;
                        push_data = {4'hF, nibble_q};
                        state_d   = StEmpty;
                    end
                end
            end
            StPad: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = {4'hF, nibble_q};
                    state_d   = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StEmpty;
            nibble_q <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 4'd0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            nibble_q <= nibble_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

`ifdef HSYM_PACKER_STATS_EN
    logic [15:0] bit_count_q, bit_count_d, sym_count_q, sym_count_d;
    logic [16:0] bit_sum;

    always_comb begin
        bit_sum     = {1'b0, bit_count_q} + {13'd0, sym_len};
        bit_count_d = bit_count_q;
        sym_count_d = sym_count_q;
        if (accept) begin
            bit_count_d = bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
            sym_count_d = (sym_count_q == 16'hFFFF) ? sym_count_q : sym_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_count_q <= 16'd0;
            sym_count_q <= 16'd0;
        end else begin
            bit_count_q <= bit_count_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign bit_count = bit_count_q;
    assign sym_count = sym_count_q;
`else
    logic unused_sym_len;
    assign unused_sym_len = ^sym_len;
`endif

endmodule
